// File: rtl/fifo_serial_tx_pkg.sv
// Shared definitions for the FIFO serial transmitter: state encoding,
// default baud divisor and a constant-width helper.
package fifo_serial_tx_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } txState_t;

  function automatic int clog2(input int value);
    int width;
    width = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) width = i + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/fifo_tx_baud_tick.sv
// Per-bit clock counter: counts 0..CLKS_PER_BIT-1, wraps, and flags the
// last clock of each serial bit with bitEnd.
module fifo_tx_baud_tick
  import fifo_serial_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  localparam int CW = clog2(CLKS_PER_BIT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  output logic [CW-1:0] clkCnt,
  output logic          bitEnd
);

  assign bitEnd = (clkCnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clkCnt <= '0;
    end else if (clear || bitEnd) begin
      clkCnt <= '0;
    end else begin
      clkCnt <= clkCnt + CW'(1);
    end
  end

endmodule

// File: rtl/fifo_serial_tx.sv
// Drains a first-word-fall-through FIFO onto a UART-style line, LSB first.
// Define FIFO_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module fifo_serial_tx
  import fifo_serial_tx_pkg::*;
#(
  parameter int BITWIDTH     = 5,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  localparam int CW  = clog2(CLKS_PER_BIT),
  localparam int BCW = (BITWIDTH > 1) ? clog2(BITWIDTH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fifoEmpty,
  input  logic [BITWIDTH-1:0] fifoDout,
  output logic                fifoREn,
  output logic                txd,
  output logic                busy,
  output logic                frameDone
);

  txState_t            state;
  logic [BITWIDTH-1:0] shiftReg;
  logic [BITWIDTH-1:0] shiftNext;
  logic [BCW-1:0]      bitCnt;
  logic [CW-1:0]       clkCnt;
  logic                bitEnd;
  logic                popNow;
  logic                lastBit;
  logic                preEnd;
`ifdef FIFO_TX_PARITY_EN
  logic                parityBit;
`endif

  fifo_tx_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) baudTick (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == IDLE),
    .clkCnt (clkCnt),
    .bitEnd (bitEnd)
  );

  // Pop only from IDLE or on the final stop clock, and never while empty.
  assign popNow    = rst && !fifoEmpty &&
                     ((state == IDLE) || ((state == STOP) && bitEnd));
  assign fifoREn   = popNow;
  assign busy      = (state != IDLE);
  assign lastBit   = (bitCnt == BCW'(BITWIDTH - 1));
  assign preEnd    = (clkCnt == CW'(CLKS_PER_BIT - 2));
  assign shiftNext = shiftReg >> 1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shiftReg  <= '0;
      bitCnt    <= '0;
      txd       <= 1'b1;
      frameDone <= 1'b0;
`ifdef FIFO_TX_PARITY_EN
      parityBit <= 1'b0;
`endif
    end else begin
      // Registered one clock early so the pulse lands on the last stop clock.
      frameDone <= (state == STOP) && preEnd;
      if (popNow) begin
        shiftReg  <= fifoDout;
        bitCnt    <= '0;
        txd       <= 1'b0;
        state     <= START;
`ifdef FIFO_TX_PARITY_EN
        parityBit <= ^fifoDout;
`endif
      end else begin
        case (state)
          IDLE: begin
            txd <= 1'b1;
          end
          START: begin
            if (bitEnd) begin
              state <= DATA;
              txd   <= shiftReg[0];
            end
          end
          DATA: begin
            if (bitEnd) begin
              shiftReg <= shiftNext;
              bitCnt   <= bitCnt + BCW'(1);
              if (lastBit) begin
`ifdef FIFO_TX_PARITY_EN
                state <= PARITY;
                txd   <= parityBit;
`else
                state <= STOP;
                txd   <= 1'b1;
`endif
              end else begin
                txd <= shiftNext[0];
              end
            end
          end
`ifdef FIFO_TX_PARITY_EN
          PARITY: begin
            if (bitEnd) begin
              state <= STOP;
              txd   <= 1'b1;
            end
          end
`endif
          STOP: begin
            if (bitEnd) begin
              state <= IDLE;
              txd   <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            txd   <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
